// File: rtl/io_input_ctrl.sv
// rtl/io_input_ctrl.sv - switch/key synchroniser, debouncer and press-flag register window
// Optional macro INPUT_IRQ_EN adds the irq mask register (offset 3) and the o_irq output.
module io_input_ctrl #(
    parameter int SW_W      = 18,
    parameter int KEY_W     = 4,
    parameter int DB_CYCLES = 1000000,
    parameter int CNT_W     = 20
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic [SW_W-1:0]   i_sw,
    input  logic [KEY_W-1:0]  i_key_n,
    input  logic [2:0]        i_addr,
    input  logic              i_rd_en,
    input  logic              i_wr_en,
    input  logic [31:0]       i_wdata,
`ifdef INPUT_IRQ_EN
    output logic              o_irq,
`endif
    output logic [31:0]       o_rdata
);

    localparam int N = SW_W + KEY_W;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);
    // Key sync flops reset to the released pin level so no phantom press qualifies after reset.
    localparam logic [N-1:0] SYNC_RST = {{KEY_W{1'b1}}, {SW_W{1'b0}}};

    logic [N-1:0]     sync1, sync2, synced;
    logic [N-1:0]     deb, deb_nxt;
    logic [CNT_W-1:0] cnt     [N];
    logic [CNT_W-1:0] cnt_nxt [N];
    logic [KEY_W-1:0] key_deb, key_rise, press_flag, w1c_mask;
    logic [SW_W-1:0]  sw_deb;
    logic [31:0]      rd_mux;
    logic             unused_wdata;

    assign synced   = {~sync2[N-1:SW_W], sync2[SW_W-1:0]};
    assign sw_deb   = deb[SW_W-1:0];
    assign key_deb  = deb[N-1:SW_W];
    assign key_rise = deb_nxt[N-1:SW_W] & ~key_deb;
    assign w1c_mask = (i_wr_en && i_addr == 3'd2) ? i_wdata[KEY_W-1:0] : '0;
    assign unused_wdata = ^i_wdata[31:KEY_W];

    always_comb begin
        deb_nxt = deb;
        for (int i = 0; i < N; i++) begin
            cnt_nxt[i] = '0;
            if (synced[i] != deb[i]) begin
                if (cnt[i] == CNT_LAST)
                    deb_nxt[i] = synced[i];
                else
                    cnt_nxt[i] = cnt[i] + 1'b1;
            end
        end
    end

`ifdef INPUT_IRQ_EN
    logic [KEY_W-1:0] irq_mask;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            irq_mask <= '0;
            o_irq    <= 1'b0;
        end else begin
            if (i_wr_en && i_addr == 3'd3)
                irq_mask <= i_wdata[KEY_W-1:0];
            o_irq <= |(press_flag & irq_mask);
        end
    end
`endif

    always_comb begin
        rd_mux = '0;
        case (i_addr)
            3'd0: rd_mux = {{(32-SW_W){1'b0}}, sw_deb};
            3'd1: rd_mux = {{(32-KEY_W){1'b0}}, key_deb};
            3'd2: rd_mux = {{(32-KEY_W){1'b0}}, press_flag};
`ifdef INPUT_IRQ_EN
            3'd3: rd_mux = {{(32-KEY_W){1'b0}}, irq_mask};
`endif
            default: rd_mux = '0;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            sync1      <= SYNC_RST;
            sync2      <= SYNC_RST;
            deb        <= '0;
            press_flag <= '0;
            o_rdata    <= '0;
            for (int i = 0; i < N; i++)
                cnt[i] <= '0;
        end else begin
            sync1 <= {i_key_n, i_sw};
            sync2 <= sync1;
            deb   <= deb_nxt;
            for (int i = 0; i < N; i++)
                cnt[i] <= cnt_nxt[i];
            // A rising edge in the same cycle as a W1C keeps the flag set.
            press_flag <= (press_flag & ~w1c_mask) | key_rise;
            if (i_rd_en)
                o_rdata <= rd_mux;
        end
    end

endmodule

// File: tb/tb_io_input_ctrl.sv
// tb/tb_io_input_ctrl.sv - directed self-checking bench for io_input_ctrl with DB_CYCLES=4
module tb_io_input_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [17:0] sw = '0;
    logic [3:0]  key_n = 4'hF;
    logic [2:0]  addr = '0;
    logic        rd_en = 1'b0;
    logic        wr_en = 1'b0;
    logic [31:0] wdata = '0;
    logic [31:0] rdata;
`ifdef INPUT_IRQ_EN
    logic        irq;
`endif

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    io_input_ctrl #(.SW_W(18), .KEY_W(4), .DB_CYCLES(4), .CNT_W(3)) dut (
        .i_clk   (clk),
        .i_rst   (rst),
        .i_sw    (sw),
        .i_key_n (key_n),
        .i_addr  (addr),
        .i_rd_en (rd_en),
        .i_wr_en (wr_en),
        .i_wdata (wdata),
`ifdef INPUT_IRQ_EN
        .o_irq   (irq),
`endif
        .o_rdata (rdata)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic rd(input logic [2:0] a);
        addr = a; rd_en = 1'b1;
        step();
        rd_en = 1'b0;
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        addr = a; wdata = d; wr_en = 1'b1;
        step();
        wr_en = 1'b0;
    endtask

    initial begin
        steps(3);
        check_eq("rst_rdata", rdata, 32'h0);
        rst = 1'b0;
        step();
        rd(0); check_eq("rst_sw", rdata, 32'h0);
        rd(1); check_eq("rst_key", rdata, 32'h0);
        rd(2); check_eq("rst_flag", rdata, 32'h0);

        // switch debounce: new value visible on the 7th continuous read
        addr = 0; rd_en = 1'b1; sw = 18'h2A5A5;
        for (int k = 1; k <= 8; k++) begin
            step();
            if (k == 6) check_eq("sw_before", rdata, 32'h0);
            if (k == 7) check_eq("sw_after", rdata, 32'h2A5A5);
        end
        sw = 18'h0;
        steps(3);
        sw = 18'h2A5A5;
        for (int k = 1; k <= 8; k++) begin
            step();
            if (k == 4 || k == 8) check_eq("sw_glitch", rdata, 32'h2A5A5);
        end

        // key1 press and release
        addr = 1; key_n = 4'b1101;
        for (int k = 1; k <= 10; k++) begin
            step();
            if (k == 6) check_eq("key_before", rdata, 32'h0);
            if (k == 10) check_eq("key_held", rdata, 32'h2);
        end
        key_n = 4'hF;
        steps(10);
        check_eq("key_released", rdata, 32'h0);
        rd_en = 1'b0;
        rd(2); check_eq("flag_sticky", rdata, 32'h2);
        wr(2, 32'h2);
        rd(2); check_eq("flag_w1c", rdata, 32'h0);

        // W1C on the exact qualifying cycle of key0
        key_n = 4'b1110;
        steps(5);
        wr(2, 32'h1);
        rd(2); check_eq("w1c_collision", rdata, 32'h1);
        wr(2, 32'h1);
        rd(2); check_eq("w1c_after", rdata, 32'h0);
        key_n = 4'hF;
        steps(8);

        // read latency and hold
        key_n = 4'b0111;
        steps(8);
        rd(1); check_eq("rd_latency", rdata, 32'h8);
        key_n = 4'hF;
        addr = 0;
        steps(10);
        check_eq("rd_hold", rdata, 32'h8);
        rd(1); check_eq("rd_key_rel", rdata, 32'h0);
        wr(5, 32'hFFFF_FFFF);
        rd(5); check_eq("rd_off5", rdata, 32'h0);
        rd(0); check_eq("off5_wr_ignored", rdata, 32'h2A5A5);

        // read and write together: read returns pre-write value
        addr = 2; wdata = 32'h8; rd_en = 1'b1; wr_en = 1'b1;
        step();
        rd_en = 1'b0; wr_en = 1'b0;
        check_eq("rdwr_prewrite", rdata, 32'h8);
        rd(2); check_eq("rdwr_cleared", rdata, 32'h0);

`ifdef INPUT_IRQ_EN
        wr(3, 32'h4);
        rd(3); check_eq("mask_rd", rdata, 32'h4);
        key_n = 4'b1101;
        steps(8);
        check_eq("irq_masked", {31'h0, irq}, 32'h0);
        key_n = 4'hF;
        steps(8);
        key_n = 4'b1011;
        for (int k = 1; k <= 7; k++) begin
            step();
            if (k == 6) check_eq("irq_flag_cycle", {31'h0, irq}, 32'h0);
            if (k == 7) check_eq("irq_set", {31'h0, irq}, 32'h1);
        end
        key_n = 4'hF;
        steps(8);
        wr(2, 32'h4);
        check_eq("irq_hold_one", {31'h0, irq}, 32'h1);
        step();
        check_eq("irq_clear", {31'h0, irq}, 32'h0);
        wr(2, 32'hF);
`else
        wr(3, 32'hF);
        rd(3); check_eq("off3_no_mask", rdata, 32'h0);
`endif

        // reset mid-debounce with switch and key0 held through it
        rd(0); check_eq("pre_reset_sw", rdata, 32'h2A5A5);
        sw = 18'h15A5A; key_n = 4'b1110;
        steps(2);
        rst = 1'b1;
        #1;
        check_eq("async_rst_rdata", rdata, 32'h0);
        steps(2);
        rst = 1'b0;
        addr = 0; rd_en = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            step();
            if (k == 6) check_eq("requal_before", rdata, 32'h0);
            if (k == 7) check_eq("requal_after", rdata, 32'h15A5A);
        end
        rd_en = 1'b0;
        rd(2); check_eq("requal_press", rdata, 32'h1);
        rd(1); check_eq("requal_key", rdata, 32'h1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
